tophat_seq_ctrl: RTL and testbench

Sequencing controller between `tophat_io_intf` and the inference engine. It turns the byte and command pulses from the IO interface into address-sequenced writes to model and feature storage. It gates `run` on complete loads, starts the engine, waits for completion with a watchdog, and holds the result. It also drives `io_ready` back to the IO interface so bytes are refused while the engine is busy.

---
 rtl/tophat_seq_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_tophat_seq_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tophat_seq_ctrl.sv
// tophat_seq_ctrl: sequences IO byte/command pulses into model and feature
// storage writes, gates and launches the engine, watches it, latches result.
//
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   model_byte_valid_i/_i    model byte strobe and data from IO
//   feature_byte_valid_i/_i  feature byte strobe and data from IO
//   run_i, clear_i           command pulses from IO
//   io_ready_o               controller idle, accepting bytes/commands
//   model_we/addr/wdata_o    model memory write port
//   feat_we/addr/wdata_o     feature buffer write port
//   eng_start_o, eng_abort_o one-cycle engine controls
//   eng_done_i, eng_result_i engine completion and result
//   busy_o                   engine run in progress
//   result_valid_o, result_o latched engine result
//   err_o                    sticky errors {timeout, run rej, busy byte, ovf}
module tophat_seq_ctrl #(
    parameter int MODEL_DEPTH = 256,
    parameter int MODEL_AW    = 8,
    parameter int FEAT_DEPTH  = 16,
    parameter int FEAT_AW     = 4,
    parameter int TIMEOUT     = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                model_byte_valid_i,
    input  logic [7:0]          model_byte_i,
    input  logic                feature_byte_valid_i,
    input  logic [7:0]          feature_byte_i,
    input  logic                run_i,
    input  logic                clear_i,
    output logic                io_ready_o,
    output logic                model_we_o,
    output logic [MODEL_AW-1:0] model_addr_o,
    output logic [7:0]          model_wdata_o,
    output logic                feat_we_o,
    output logic [FEAT_AW-1:0]  feat_addr_o,
    output logic [7:0]          feat_wdata_o,
    output logic                eng_start_o,
    output logic                eng_abort_o,
    input  logic                eng_done_i,
    input  logic [7:0]          eng_result_i,
    output logic                busy_o,
    output logic                result_valid_o,
    output logic [7:0]          result_o,
    output logic [3:0]          err_o
);

    localparam int WD_W = $clog2(TIMEOUT);
    localparam logic [MODEL_AW:0] M_FULL  = (MODEL_AW+1)'(MODEL_DEPTH);
    localparam logic [FEAT_AW:0]  F_FULL  = (FEAT_AW+1)'(FEAT_DEPTH);
    localparam logic [WD_W-1:0]   WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT
    } state_t;

    state_t              state_q, state_d;
    logic [MODEL_AW:0]   model_cnt_q, model_cnt_d;
    logic [FEAT_AW:0]    feat_cnt_q, feat_cnt_d;
    logic [WD_W-1:0]     wdog_q, wdog_d;

    logic                ready_d, busy_d;
    logic                model_we_d, feat_we_d;
    logic [MODEL_AW-1:0] model_addr_d;
    logic [FEAT_AW-1:0]  feat_addr_d;
    logic [7:0]          model_wdata_d, feat_wdata_d;
    logic                start_d, abort_d;
    logic                rv_d;
    logic [7:0]          result_d;
    logic [3:0]          err_d;
    logic                byte_any;

    assign byte_any = model_byte_valid_i | feature_byte_valid_i;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            model_cnt_q    <= '0;
            feat_cnt_q     <= '0;
            wdog_q         <= '0;
            io_ready_o     <= 1'b0;
            busy_o         <= 1'b0;
            model_we_o     <= 1'b0;
            model_addr_o   <= '0;
            model_wdata_o  <= '0;
            feat_we_o      <= 1'b0;
            feat_addr_o    <= '0;
            feat_wdata_o   <= '0;
            eng_start_o    <= 1'b0;
            eng_abort_o    <= 1'b0;
            result_valid_o <= 1'b0;
            result_o       <= '0;
            err_o          <= '0;
        end else begin
            state_q        <= state_d;
            model_cnt_q    <= model_cnt_d;
            feat_cnt_q     <= feat_cnt_d;
            wdog_q         <= wdog_d;
            io_ready_o     <= ready_d;
            busy_o         <= busy_d;
            model_we_o     <= model_we_d;
            model_addr_o   <= model_addr_d;
            model_wdata_o  <= model_wdata_d;
            feat_we_o      <= feat_we_d;
            feat_addr_o    <= feat_addr_d;
            feat_wdata_o   <= feat_wdata_d;
            eng_start_o    <= start_d;
            eng_abort_o    <= abort_d;
            result_valid_o <= rv_d;
            result_o       <= result_d;
            err_o          <= err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        model_cnt_d   = model_cnt_q;
        feat_cnt_d    = feat_cnt_q;
        wdog_d        = wdog_q;
        model_we_d    = 1'b0;
        model_addr_d  = model_addr_o;
        model_wdata_d = model_wdata_o;
        feat_we_d     = 1'b0;
        feat_addr_d   = feat_addr_o;
        feat_wdata_d  = feat_wdata_o;
        start_d       = 1'b0;
        abort_d       = 1'b0;
        rv_d          = result_valid_o;
        result_d      = result_o;
        err_d         = err_o;

        if (clear_i) begin
            // result_o is deliberately kept; only its valid flag drops
            model_cnt_d = '0;
            feat_cnt_d  = '0;
            rv_d        = 1'b0;
            err_d       = '0;
            abort_d     = (state_q != S_IDLE);
            state_d     = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (model_byte_valid_i) begin
                        if (model_cnt_q < M_FULL) begin
                            model_we_d    = 1'b1;
                            model_addr_d  = model_cnt_q[MODEL_AW-1:0];
                            model_wdata_d = model_byte_i;
                            model_cnt_d   = model_cnt_q + (MODEL_AW+1)'(1);
                        end else begin
                            err_d[0] = 1'b1;
                        end
                    end
                    if (feature_byte_valid_i) begin
                        if (feat_cnt_q < F_FULL) begin
                            feat_we_d    = 1'b1;
                            feat_addr_d  = feat_cnt_q[FEAT_AW-1:0];
                            feat_wdata_d = feature_byte_i;
                            feat_cnt_d   = feat_cnt_q + (FEAT_AW+1)'(1);
                        end else begin
                            err_d[0] = 1'b1;
                        end
                    end
                    if (run_i) begin
                        if (model_cnt_q == M_FULL && feat_cnt_q == F_FULL) begin
                            // start is registered, so it shows during START
                            state_d = S_START;
                            start_d = 1'b1;
                            rv_d    = 1'b0;
                        end else begin
                            err_d[2] = 1'b1;
                        end
                    end
                end
                S_START: begin
                    if (byte_any) err_d[1] = 1'b1;
                    wdog_d  = '0;
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (byte_any) err_d[1] = 1'b1;
                    // done takes precedence over an expiring watchdog
                    if (eng_done_i) begin
                        result_d   = eng_result_i;
                        rv_d       = 1'b1;
                        feat_cnt_d = '0;
                        state_d    = S_IDLE;
                    end else if (wdog_q == WD_LAST) begin
                        abort_d    = 1'b1;
                        err_d[3]   = 1'b1;
                        feat_cnt_d = '0;
                        state_d    = S_IDLE;
                    end else begin
                        wdog_d = wdog_q + WD_W'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // ready/busy follow the state being entered, not the current one
        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d != S_IDLE);
    end

endmodule

// File: tb/tb_tophat_seq_ctrl.sv
// Testbench for tophat_seq_ctrl: write scoreboard, table-driven control
// vectors and hand-written run/timeout/clear sequences.
module tb_tophat_seq_ctrl;

    logic       clk;
    logic       rst_n;
    logic       model_byte_valid_i;
    logic [7:0] model_byte_i;
    logic       feature_byte_valid_i;
    logic [7:0] feature_byte_i;
    logic       run_i;
    logic       clear_i;
    logic       eng_done_i;
    logic [7:0] eng_result_i;

    logic       io_ready_o, model_we_o, feat_we_o;
    logic [7:0] model_addr_o, model_wdata_o, feat_wdata_o;
    logic [3:0] feat_addr_o;
    logic       eng_start_o, eng_abort_o, busy_o, result_valid_o;
    logic [7:0] result_o;
    logic [3:0] err_o;

    logic       t_ready, t_mwe, t_fwe;
    logic [7:0] t_maddr, t_mwdata, t_fwdata;
    logic [3:0] t_faddr;
    logic       t_start, t_abort, t_busy, t_rv;
    logic [7:0] t_result;
    logic [3:0] t_err;

    tophat_seq_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .model_byte_valid_i(model_byte_valid_i),
        .model_byte_i(model_byte_i),
        .feature_byte_valid_i(feature_byte_valid_i),
        .feature_byte_i(feature_byte_i),
        .run_i(run_i), .clear_i(clear_i),
        .io_ready_o(io_ready_o),
        .model_we_o(model_we_o), .model_addr_o(model_addr_o),
        .model_wdata_o(model_wdata_o),
        .feat_we_o(feat_we_o), .feat_addr_o(feat_addr_o),
        .feat_wdata_o(feat_wdata_o),
        .eng_start_o(eng_start_o), .eng_abort_o(eng_abort_o),
        .eng_done_i(eng_done_i), .eng_result_i(eng_result_i),
        .busy_o(busy_o), .result_valid_o(result_valid_o),
        .result_o(result_o), .err_o(err_o)
    );

    tophat_seq_ctrl #(.TIMEOUT(8)) dut_to (
        .clk(clk), .rst_n(rst_n),
        .model_byte_valid_i(model_byte_valid_i),
        .model_byte_i(model_byte_i),
        .feature_byte_valid_i(feature_byte_valid_i),
        .feature_byte_i(feature_byte_i),
        .run_i(run_i), .clear_i(clear_i),
        .io_ready_o(t_ready),
        .model_we_o(t_mwe), .model_addr_o(t_maddr),
        .model_wdata_o(t_mwdata),
        .feat_we_o(t_fwe), .feat_addr_o(t_faddr),
        .feat_wdata_o(t_fwdata),
        .eng_start_o(t_start), .eng_abort_o(t_abort),
        .eng_done_i(1'b0), .eng_result_i(8'h00),
        .busy_o(t_busy), .result_valid_o(t_rv),
        .result_o(t_result), .err_o(t_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int n_start = 0;
    int m_cnt = 0;
    int f_cnt = 0;
    bit tb_busy = 1'b0;
    logic [15:0] mq[$];
    logic [11:0] fq[$];
    logic [15:0] exp_m;
    logic [11:0] exp_f;

    typedef struct {
        logic       mv, fv, run, clr, done;
        logic [7:0] din, eres;
        logic       rdy, busy, start, abort, rv;
        logic [7:0] res;
        logic [3:0] err;
    } vec_t;
    vec_t tbl[7];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && model_we_o === 1'b1) begin
            if (mq.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL model_wr_unexpected: got addr %0h data %0h expected none",
                         model_addr_o, model_wdata_o);
            end else begin
                exp_m = mq.pop_front();
                chk("model_wr", {model_addr_o, model_wdata_o}, exp_m);
            end
        end
        if (rst_n === 1'b1 && feat_we_o === 1'b1) begin
            if (fq.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL feat_wr_unexpected: got addr %0h data %0h expected none",
                         feat_addr_o, feat_wdata_o);
            end else begin
                exp_f = fq.pop_front();
                chk("feat_wr", {feat_addr_o, feat_wdata_o}, exp_f);
            end
        end
        if (rst_n === 1'b1 && eng_start_o === 1'b1) n_start++;
    end

    task automatic cyc(input logic mv, input logic fv, input logic run,
                       input logic clr, input logic done,
                       input logic [7:0] din, input logic [7:0] eres);
        model_byte_valid_i   = mv;
        model_byte_i         = mv ? din : 8'h00;
        feature_byte_valid_i = fv;
        feature_byte_i       = fv ? din : 8'h00;
        run_i                = run;
        clear_i              = clr;
        eng_done_i           = done;
        eng_result_i         = eres;
        @(posedge clk);
        #1;
        model_byte_valid_i   = 1'b0;
        model_byte_i         = 8'h00;
        feature_byte_valid_i = 1'b0;
        feature_byte_i       = 8'h00;
        run_i                = 1'b0;
        clear_i              = 1'b0;
        eng_done_i           = 1'b0;
        eng_result_i         = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, 0, 0, 0, 0, 8'h00, 8'h00);
    endtask

    task automatic mbyte(input logic [7:0] d);
        if (!tb_busy && m_cnt < 256) begin
            mq.push_back({8'(m_cnt), d});
            m_cnt++;
        end
        cyc(1, 0, 0, 0, 0, d, 8'h00);
    endtask

    task automatic fbyte(input logic [7:0] d);
        if (!tb_busy && f_cnt < 16) begin
            fq.push_back({4'(f_cnt), d});
            f_cnt++;
        end
        cyc(0, 1, 0, 0, 0, d, 8'h00);
    endtask

    task automatic load(input logic [7:0] fbase);
        for (int i = m_cnt; i < 256; i++) mbyte(8'(i));
        for (int i = f_cnt; i < 16; i++) fbyte(fbase + 8'(i));
    endtask

    initial begin
        tbl[0] = '{0,0,1,0,0,8'h00,8'h00, 0,1,1,0,0,8'h21,4'b0100};
        tbl[1] = '{0,0,0,0,0,8'h00,8'h00, 0,1,0,0,0,8'h21,4'b0100};
        tbl[2] = '{0,1,0,0,0,8'h99,8'h00, 0,1,0,0,0,8'h21,4'b0110};
        tbl[3] = '{0,0,0,1,0,8'h00,8'h00, 1,0,0,1,0,8'h21,4'b0000};
        tbl[4] = '{0,0,0,0,1,8'h00,8'h33, 1,0,0,0,0,8'h21,4'b0000};
        tbl[5] = '{0,0,1,0,0,8'h00,8'h00, 1,0,0,0,0,8'h21,4'b0100};
        tbl[6] = '{0,0,1,1,0,8'h00,8'h00, 1,0,0,0,0,8'h21,4'b0000};

        rst_n = 1'b0;
        model_byte_valid_i = 1'b0; model_byte_i = 8'h00;
        feature_byte_valid_i = 1'b0; feature_byte_i = 8'h00;
        run_i = 1'b0; clear_i = 1'b0;
        eng_done_i = 1'b0; eng_result_i = 8'h00;

        // reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", io_ready_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_rv", result_valid_o, 0);
        chk("rst_result", result_o, 0);
        chk("rst_we", {model_we_o, feat_we_o, eng_start_o, eng_abort_o}, 0);
        chk("rst_to_ready", t_ready, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_ready", io_ready_o, 1);

        // full load and run
        load(8'hA0);
        cyc(0, 0, 1, 0, 0, 8'h00, 8'h00);
        tb_busy = 1'b1;
        chk("run_start", eng_start_o, 1);
        chk("run_busy", busy_o, 1);
        chk("run_ready", io_ready_o, 0);
        idle(19);
        cyc(0, 0, 0, 0, 1, 8'h00, 8'h5C);
        tb_busy = 1'b0;
        f_cnt = 0;
        chk("done_rv", result_valid_o, 1);
        chk("done_result", result_o, 8'h5C);
        chk("done_busy", busy_o, 0);
        chk("done_ready", io_ready_o, 1);
        chk("done_err", err_o, 0);
        chk("start_count", n_start, 1);

        // overflow, then run with err[0] held, busy drop
        mbyte(8'h77);
        chk("ovf_model_err", err_o, 4'b0001);
        load(8'hB0);
        fbyte(8'hEE);
        chk("ovf_feat_err", err_o, 4'b0001);
        cyc(0, 0, 1, 0, 0, 8'h00, 8'h00);
        tb_busy = 1'b1;
        chk("ovf_run_start", eng_start_o, 1);
        idle(1);
        fbyte(8'h55);
        chk("busy_err", err_o, 4'b0011);
        chk("busy_ready", io_ready_o, 0);
        chk("busy_busy", busy_o, 1);
        cyc(0, 0, 0, 0, 1, 8'h00, 8'h21);
        tb_busy = 1'b0;
        f_cnt = 0;
        chk("done2_result", {result_valid_o, result_o}, {1'b1, 8'h21});

        // clear in IDLE, then run rejected after 255 model bytes
        cyc(0, 0, 0, 1, 0, 8'h00, 8'h00);
        m_cnt = 0;
        f_cnt = 0;
        chk("clr_idle_err", err_o, 0);
        chk("clr_idle_abort", eng_abort_o, 0);
        chk("clr_idle_rv", {result_valid_o, result_o}, {1'b0, 8'h21});
        for (int i = 0; i < 255; i++) mbyte(8'(255 - i));
        cyc(0, 0, 1, 0, 0, 8'h00, 8'h00);
        chk("rej_err", err_o, 4'b0100);
        chk("rej_start", eng_start_o, 0);
        chk("rej_busy", {busy_o, io_ready_o}, 2'b01);
        load(8'h10);

        // control vectors: run, busy byte, clear in WAIT, late done
        for (int i = 0; i < 7; i++) begin
            cyc(tbl[i].mv, tbl[i].fv, tbl[i].run, tbl[i].clr, tbl[i].done,
                tbl[i].din, tbl[i].eres);
            chk($sformatf("tbl%0d_ready", i), io_ready_o, tbl[i].rdy);
            chk($sformatf("tbl%0d_busy", i), busy_o, tbl[i].busy);
            chk($sformatf("tbl%0d_start", i), eng_start_o, tbl[i].start);
            chk($sformatf("tbl%0d_abort", i), eng_abort_o, tbl[i].abort);
            chk($sformatf("tbl%0d_rv", i), result_valid_o, tbl[i].rv);
            chk($sformatf("tbl%0d_result", i), result_o, tbl[i].res);
            chk($sformatf("tbl%0d_err", i), err_o, tbl[i].err);
        end
        m_cnt = 0;
        f_cnt = 0;

        // clear and run together on a full load
        load(8'hC0);
        cyc(0, 0, 1, 1, 0, 8'h00, 8'h00);
        m_cnt = 0;
        f_cnt = 0;
        chk("clrrun_start", eng_start_o, 0);
        chk("clrrun_busy", {busy_o, io_ready_o}, 2'b01);
        chk("clrrun_err", err_o, 0);
        idle(1);
        chk("clrrun_start2", eng_start_o, 0);

        // watchdog on the TIMEOUT=8 instance
        load(8'hD0);
        cyc(0, 0, 1, 0, 0, 8'h00, 8'h00);
        tb_busy = 1'b1;
        chk("to_start", t_start, 1);
        chk("to_abort_t1", t_abort, 0);
        for (int j = 1; j <= 9; j++) begin
            idle(1);
            chk($sformatf("to_abort_t%0d", j + 1), t_abort, (j == 9));
        end
        chk("to_err", t_err, 4'b1000);
        chk("to_rv", t_rv, 0);
        chk("to_ready", {t_ready, t_busy}, 2'b10);
        for (int i = 0; i < 16; i++) begin
            cyc(0, 1, 0, 0, 0, 8'hE0 + 8'(i), 8'h00);
            chk($sformatf("to_fwr%0d", i), {t_fwe, t_faddr, t_fwdata},
                {1'b1, 4'(i), 8'hE0 + 8'(i)});
        end
        cyc(0, 0, 1, 0, 0, 8'h00, 8'h00);
        chk("to_rerun_start", t_start, 1);
        chk("to_rerun_busy", {t_busy, t_ready}, 2'b10);
        idle(3);

        chk("model_q_drained", mq.size(), 0);
        chk("feat_q_drained", fq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
